// File: rtl/compare_requester.sv
// compare_requester: clocked four-phase requester for a self-timed equality comparator.
// Operands go out on cmp_req/cmp_x/cmp_y; fin/equal/notEqual return through synchronisers.
module compare_requester #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             cmp_req,
    output logic [WIDTH-1:0] cmp_x,
    output logic [WIDTH-1:0] cmp_y,
    input  logic             cmp_fin,
    input  logic             cmp_equal,
    input  logic             cmp_not_equal,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_equal,
    output logic             res_err,
    output logic             busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
    localparam logic [2:0] IDLE = 3'd0, ASSERT = 3'd1, SETTLE = 3'd2, RELEASE = 3'd3, OUTPUT = 3'd4;

    logic [2:0] state;
    logic [CW-1:0] cnt;
    logic [SYNC_STAGES-1:0] fin_q, eq_q, ne_q, vld_q;
    logic fin_s, eq_s, ne_s, vld_s;

    assign fin_s = fin_q[SYNC_STAGES-1];
    assign eq_s = eq_q[SYNC_STAGES-1];
    assign ne_s = ne_q[SYNC_STAGES-1];
    assign vld_s = vld_q[SYNC_STAGES-1];
    // vld_q fills with ones after reset so fin_s is only trusted once the chain holds real samples
    assign in_ready = (state == IDLE) && vld_s && !fin_s;
    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fin_q <= '0;
            eq_q <= '0;
            ne_q <= '0;
            vld_q <= '0;
        end else begin
            fin_q <= {fin_q[SYNC_STAGES-2:0], cmp_fin};
            eq_q <= {eq_q[SYNC_STAGES-2:0], cmp_equal};
            ne_q <= {ne_q[SYNC_STAGES-2:0], cmp_not_equal};
            vld_q <= {vld_q[SYNC_STAGES-2:0], 1'b1};
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            cmp_req <= 1'b0;
            cmp_x <= '0;
            cmp_y <= '0;
            res_valid <= 1'b0;
            res_equal <= 1'b0;
            res_err <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (in_valid && in_ready) begin
                        cmp_x <= in_x;
                        cmp_y <= in_y;
                        cmp_req <= 1'b1;
                        cnt <= '0;
                        state <= ASSERT;
                    end
                ASSERT:
                    if (fin_s) state <= SETTLE;
                    else if (cnt == TMAX) begin
                        res_err <= 1'b1;
                        cmp_req <= 1'b0;
                        cnt <= '0;
                        state <= RELEASE;
                    end else cnt <= cnt + 1'b1;
                SETTLE: begin
                    res_equal <= eq_s;
                    res_err <= eq_s == ne_s;
                    cmp_req <= 1'b0;
                    cnt <= '0;
                    state <= RELEASE;
                end
                RELEASE:
                    if (!fin_s || cnt == TMAX) begin
                        res_err <= res_err || fin_s;
                        res_valid <= 1'b1;
                        state <= OUTPUT;
                    end else cnt <= cnt + 1'b1;
                OUTPUT:
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_err <= 1'b0;
                        state <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_compare_requester.sv
// tb_compare_requester: table, hand-written and random checks of compare_requester
// against a delayed-echo comparator model.
module tb_compare_requester;
    localparam int TO = 15, SS = 2;

    typedef struct {
        logic [31:0] x, y;
        int d, mode;
        logic exp_eq, exp_err;
    } vec_t;

    logic clk = 0, rst = 1, in_valid = 0, res_ready = 0;
    logic [31:0] in_x = 0, in_y = 0;
    logic in_ready, cmp_req, cmp_fin, cmp_equal, cmp_not_equal, res_valid, res_equal, res_err, busy;
    logic [31:0] cmp_x, cmp_y;
    int checks = 0, errors = 0;
    int d = 3, mode = 0;
    logic force_fin = 0, mon_en = 1;
    logic [15:0] hist = '0;
    logic [16:0] line;
    int ready_viol = 0, stab_viol = 0, req_rises = 0, rv_rises = 0;
    logic prev_hold = 0, prev_req = 0, prev_rv = 0;
    logic [31:0] px = 0, py = 0;

    compare_requester #(.WIDTH(32), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .cmp_req(cmp_req), .cmp_x(cmp_x), .cmp_y(cmp_y), .cmp_fin(cmp_fin), .cmp_equal(cmp_equal),
        .cmp_not_equal(cmp_not_equal), .res_valid(res_valid), .res_ready(res_ready),
        .res_equal(res_equal), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // comparator model: mode 0 honest, 1 never answers, 2 raises equal and notEqual together
    always @(posedge clk) hist <= {hist[14:0], cmp_req};
    assign line = {hist, cmp_req};
    assign cmp_fin = (mode != 1) && (line[d] || force_fin);
    assign cmp_equal = cmp_fin && (mode == 2 || cmp_x == cmp_y);
    assign cmp_not_equal = cmp_fin && (mode == 2 || cmp_x != cmp_y);

    always @(negedge clk) begin
        if (busy && in_ready) ready_viol++;
        if (mon_en && prev_hold && (cmp_req || cmp_fin) && (cmp_x !== px || cmp_y !== py)) stab_viol++;
        prev_hold = cmp_req || cmp_fin;
        px = cmp_x;
        py = cmp_y;
        if (cmp_req && !prev_req) req_rises++;
        prev_req = cmp_req;
        if (res_valid && !prev_rv) rv_rises++;
        prev_rv = res_valid;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        @(negedge clk);
        in_x = x;
        in_y = y;
        in_valid = 1;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic get_result(output logic eq, output logic err, input int hold);
        int n = 0, hv = 0;
        res_ready = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 300);
        check("result_arrives", res_valid, 1);
        eq = res_equal;
        err = res_err;
        if (!res_valid) return;
        repeat (hold) begin
            @(negedge clk);
            if (!res_valid || res_equal !== eq || res_err !== err) hv++;
        end
        if (hold > 0) check("result_held", hv, 0);
        res_ready = 1;
        @(posedge clk);
        #1 res_ready = 0;
        check("res_valid_drop", res_valid, 0);
    endtask

    function automatic logic [1:0] predict(input logic [31:0] x, input logic [31:0] y, input int m);
        return {x == y, m != 0};
    endfunction

    initial begin
        vec_t tbl[6];
        logic [31:0] bx[4], by[4], x, y;
        logic eq, err;
        logic [1:0] p;
        int r0, v0, n;
        tbl[0] = '{32'h1234_5678, 32'h1234_5678, 3, 0, 1'b1, 1'b0};
        tbl[1] = '{32'h0000_0000, 32'h8000_0000, 0, 0, 1'b0, 1'b0};
        tbl[2] = '{32'hffff_ffff, 32'hffff_ffff, 1, 0, 1'b1, 1'b0};
        tbl[3] = '{32'ha5a5_a5a5, 32'ha5a5_a5a4, 5, 0, 1'b0, 1'b0};
        tbl[4] = '{32'h0000_0001, 32'h0000_0001, 2, 2, 1'b1, 1'b1};
        tbl[5] = '{32'h0000_0000, 32'h0000_0000, 6, 0, 1'b1, 1'b0};
        bx = '{32'h11, 32'h22, 32'h33, 32'h44};
        by = '{32'h11, 32'h23, 32'h33, 32'h45};

        repeat (3) @(negedge clk);
        check("rst_cmp_req", cmp_req, 0);
        check("rst_cmp_x", cmp_x, 0);
        check("rst_cmp_y", cmp_y, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_equal", res_equal, 0);
        check("rst_res_err", res_err, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 0;
        @(posedge clk);
        #1 check("ready_after_1", in_ready, 0);
        @(posedge clk);
        #1 check("ready_after_2", in_ready, 1);

        @(negedge clk);
        res_ready = 1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (res_valid || busy) n++;
        end
        res_ready = 0;
        check("idle_res_ready_ignored", n, 0);

        foreach (tbl[i]) begin
            repeat (20) @(negedge clk);
            d = tbl[i].d;
            mode = tbl[i].mode;
            r0 = req_rises;
            v0 = rv_rises;
            send(tbl[i].x, tbl[i].y);
            get_result(eq, err, 0);
            check("tbl_err", err, tbl[i].exp_err);
            if (!tbl[i].exp_err) check("tbl_equal", eq, tbl[i].exp_eq);
            check("tbl_req_pulses", req_rises - r0, 1);
            check("tbl_res_pulses", rv_rises - v0, 1);
        end

        // silent comparator: request must be withdrawn after TIMEOUT+1 cycles
        repeat (20) @(negedge clk);
        mode = 1;
        d = 3;
        send(32'hdead_beef, 32'hdead_beef);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!cmp_req) break;
            n++;
        end
        check("timeout_req_cycles", n, TO + 1);
        get_result(eq, err, 0);
        check("timeout_err", err, 1);

        // both verdict rails high, then fin stuck high after request drop
        repeat (20) @(negedge clk);
        mode = 2;
        d = 2;
        send(32'h5, 32'h6);
        force_fin = 1;
        get_result(eq, err, 0);
        check("protocol_err", err, 1);
        @(negedge clk);
        in_x = 5;
        in_y = 5;
        in_valid = 1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || in_ready || cmp_req) n++;
        end
        check("no_accept_while_fin", n, 0);
        force_fin = 0;
        mode = 0;
        send(32'h5, 32'h5);
        get_result(eq, err, 0);
        check("recover_err", err, 0);
        check("recover_equal", eq, 1);

        repeat (20) @(negedge clk);
        d = 1;
        fork
            begin
                for (int k = 0; k < 4; k++) send(bx[k], by[k]);
            end
            begin
                logic e, r;
                for (int j = 0; j < 4; j++) begin
                    get_result(e, r, j == 1 ? 10 : 0);
                    check("b2b_err", r, 0);
                    check("b2b_equal", e, bx[j] == by[j]);
                end
            end
        join

        for (int it = 0; it < 40; it++) begin
            repeat (20) @(negedge clk);
            d = $urandom_range(0, 6);
            mode = ($urandom_range(0, 7) == 0) ? 2 : 0;
            x = $urandom;
            y = $urandom_range(0, 1) ? x : x ^ (32'h1 << $urandom_range(0, 31));
            p = predict(x, y, mode);
            send(x, y);
            get_result(eq, err, $urandom_range(0, 3));
            check("rand_err", err, p[0]);
            if (!p[0]) check("rand_equal", eq, p[1]);
        end

        // reset in ASSERT while fin is high
        repeat (20) @(negedge clk);
        mon_en = 0;
        mode = 0;
        d = 3;
        send(32'h7, 32'h7);
        n = 0;
        while (!cmp_fin && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("fin_seen_before_rst", cmp_fin, 1);
        check("busy_before_rst", busy, 1);
        force_fin = 1;
        rst = 1;
        #1;
        check("rst_mid_cmp_req", cmp_req, 0);
        check("rst_mid_res_valid", res_valid, 0);
        check("rst_mid_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_ready) n++;
        end
        check("ready_low_fin_high", n, 0);
        @(negedge clk);
        force_fin = 0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 n++;
            if (in_ready) break;
        end
        check("release_to_ready", n, SS);
        mon_en = 1;
        send(32'h9, 32'ha);
        get_result(eq, err, 0);
        check("post_rst_err", err, 0);
        check("post_rst_equal", eq, 0);

        check("in_ready_while_busy", ready_viol, 0);
        check("operand_stability", stab_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
